axi_cdc_dst_drain_ctrl: RTL and testbench



---
 rtl/axi_cdc_dst_drain_ctrl_pkg.sv | 61 ++++++
 rtl/axi_cdc_dst_drain_ctrl_txn_cnt.sv | 42 ++++
 rtl/axi_cdc_dst_drain_ctrl.sv | 117 +++++++++++
 tb/tb_axi_cdc_dst_drain_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_cdc_dst_drain_ctrl_pkg.sv
// Shared AXI channel and bundle types for the CDC destination-side drain controller.
package axi_cdc_dst_drain_ctrl_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef logic [IdWidth-1:0]   id_t;
    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ax_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } dst_axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } dst_axi_resp_t;

endpackage

// File: rtl/axi_cdc_dst_drain_ctrl_txn_cnt.sv
// Saturating up/down transaction counter; a decrement at zero holds zero and flags underflow.
module axi_cdc_txn_cnt #(
    parameter int unsigned Max   = 8,
    parameter int unsigned Width = $clog2(Max + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [Width-1:0] count_o,
    output logic             is_zero_o,
    output logic             is_max_o,
    output logic             underflow_o
);

    localparam logic [Width-1:0] MaxCount = Width'(Max);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d     = count_q;
        underflow_o = dec_i && (count_q == '0);
        if (inc_i && !dec_i && (count_q != MaxCount)) begin
            count_d = count_q + Width'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign is_zero_o = (count_q == '0);
    assign is_max_o  = (count_q >= MaxCount);

endmodule

// File: rtl/axi_cdc_dst_drain_ctrl.sv
// Drain/isolation controller on the destination master side of an AXI CDC: caps outstanding
// transactions, stops new AW/AR on request and reports isolation once everything has completed.
module axi_cdc_dst_drain_ctrl
    import axi_cdc_dst_drain_ctrl_pkg::*;
#(
    parameter int unsigned MaxWrTxns = 8,
    parameter int unsigned MaxRdTxns = 8,
    parameter type axi_req_t  = dst_axi_req_t,
    parameter type axi_resp_t = dst_axi_resp_t
) (
    input  logic      dst_clk_i,
    input  logic      dst_rst_ni,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i,
    input  logic      isolate_i,
    output logic      isolated_o,
    output logic      cnt_err_o
);

    localparam int unsigned WrCntW = $clog2(MaxWrTxns + 1);
    localparam int unsigned RdCntW = $clog2(MaxRdTxns + 1);

    typedef enum logic [1:0] {NORMAL, DRAIN, ISOLATED} state_e;

    state_e state_q, state_d;
    logic   cnt_err_q, cnt_err_d;

    logic aw_allow, w_allow, ar_allow;
    logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

    logic [WrCntW-1:0] wr_cnt, w_pend;
    logic [RdCntW-1:0] rd_cnt;
    logic wr_zero, wr_max, wr_uflow;
    logic wp_zero, wp_max, wp_uflow;
    logic rd_zero, rd_max, rd_uflow;
    logic unused_obs;

    // Allows depend only on registered state, so no ready ever feeds back into a valid.
    always_comb begin
        aw_allow = (state_q == NORMAL) && !wr_max;
        ar_allow = (state_q == NORMAL) && !rd_max;
        w_allow  = !wp_zero;
    end

    assign aw_hs     = slv_req_i.aw_valid && aw_allow && mst_resp_i.aw_ready;
    assign w_last_hs = slv_req_i.w_valid && w_allow && mst_resp_i.w_ready && slv_req_i.w.last;
    assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
    assign ar_hs     = slv_req_i.ar_valid && ar_allow && mst_resp_i.ar_ready;
    assign r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & aw_allow;
        mst_req_o.w_valid  = slv_req_i.w_valid & w_allow;
        mst_req_o.ar_valid = slv_req_i.ar_valid & ar_allow;

        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & w_allow;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
    end

    axi_cdc_txn_cnt #(.Max(MaxWrTxns), .Width(WrCntW)) u_wr_cnt (
        .clk_i(dst_clk_i), .rst_ni(dst_rst_ni), .inc_i(aw_hs), .dec_i(b_hs),
        .count_o(wr_cnt), .is_zero_o(wr_zero), .is_max_o(wr_max), .underflow_o(wr_uflow)
    );

    axi_cdc_txn_cnt #(.Max(MaxWrTxns), .Width(WrCntW)) u_w_pend (
        .clk_i(dst_clk_i), .rst_ni(dst_rst_ni), .inc_i(aw_hs), .dec_i(w_last_hs),
        .count_o(w_pend), .is_zero_o(wp_zero), .is_max_o(wp_max), .underflow_o(wp_uflow)
    );

    axi_cdc_txn_cnt #(.Max(MaxRdTxns), .Width(RdCntW)) u_rd_cnt (
        .clk_i(dst_clk_i), .rst_ni(dst_rst_ni), .inc_i(ar_hs), .dec_i(r_last_hs),
        .count_o(rd_cnt), .is_zero_o(rd_zero), .is_max_o(rd_max), .underflow_o(rd_uflow)
    );

    // Counts are kept for observation; w_pend cannot underflow or saturate because W is gated on it.
    assign unused_obs = ^{wr_cnt, w_pend, rd_cnt, wp_max, wp_uflow};

    always_comb begin
        state_d   = state_q;
        cnt_err_d = cnt_err_q | wr_uflow | rd_uflow;
        unique case (state_q)
            NORMAL: begin
                if (isolate_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!isolate_i) begin
                    state_d = NORMAL;
                end else if (wr_zero && wp_zero && rd_zero && !b_hs && !r_last_hs) begin
                    state_d = ISOLATED;
                end
            end
            ISOLATED: begin
                if (!isolate_i) state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge dst_clk_i) begin
        if (!dst_rst_ni) begin
            state_q   <= NORMAL;
            cnt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign isolated_o = (state_q == ISOLATED);
    assign cnt_err_o  = cnt_err_q;

endmodule

// File: tb/tb_axi_cdc_dst_drain_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_axi_cdc_dst_drain_ctrl;
    import axi_cdc_dst_drain_ctrl_pkg::*;

    localparam int unsigned MAXW = 3;
    localparam int unsigned MAXR = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          isolate;
    logic          isolated;
    logic          cnt_err;
    dst_axi_req_t  slv_req, mst_req;
    dst_axi_resp_t slv_resp, mst_resp;

    int checks;
    int errors;

    // Reference model: mode 0 normal, 1 draining, 2 isolated; plain outstanding counts.
    int m_mode, m_wr, m_wp, m_rd;
    bit m_err;
    bit h_aw, h_wl, h_b, h_ar, h_rl;

    always #5 clk = ~clk;

    axi_cdc_dst_drain_ctrl #(
        .MaxWrTxns (MAXW),
        .MaxRdTxns (MAXR),
        .axi_req_t (dst_axi_req_t),
        .axi_resp_t(dst_axi_resp_t)
    ) dut (
        .dst_clk_i (clk),
        .dst_rst_ni(rst_n),
        .slv_req_i (slv_req),
        .slv_resp_o(slv_resp),
        .mst_req_o (mst_req),
        .mst_resp_i(mst_resp),
        .isolate_i (isolate),
        .isolated_o(isolated),
        .cnt_err_o (cnt_err)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        slv_req          = '0;
        slv_req.b_ready  = 1'b1;
        slv_req.r_ready  = 1'b1;
        mst_resp         = '0;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
    endtask

    task automatic rand_ax(output ax_chan_t ax);
        ax.id    = id_t'($urandom);
        ax.addr  = $urandom;
        ax.len   = 8'($urandom_range(0, 3));
        ax.size  = 3'd2;
        ax.burst = 2'b01;
    endtask

    task automatic eval_and_check();
        bit            aw_ok, w_ok, ar_ok;
        dst_axi_req_t  er;
        dst_axi_resp_t es;
        #1;
        aw_ok = (m_mode == 0) && (m_wr < int'(MAXW));
        ar_ok = (m_mode == 0) && (m_rd < int'(MAXR));
        w_ok  = (m_wp > 0);
        er = slv_req;
        er.aw_valid = slv_req.aw_valid && aw_ok;
        er.w_valid  = slv_req.w_valid && w_ok;
        er.ar_valid = slv_req.ar_valid && ar_ok;
        es = mst_resp;
        es.aw_ready = mst_resp.aw_ready && aw_ok;
        es.w_ready  = mst_resp.w_ready && w_ok;
        es.ar_ready = mst_resp.ar_ready && ar_ok;
        chk("mst_req", 256'(mst_req), 256'(er));
        chk("slv_resp", 256'(slv_resp), 256'(es));
        chk("isolated", 256'(isolated), 256'(m_mode == 2));
        chk("cnt_err", 256'(cnt_err), 256'(m_err));
        chk("wr_cnt", 256'(dut.wr_cnt), 256'(m_wr));
        chk("w_pend", 256'(dut.w_pend), 256'(m_wp));
        chk("rd_cnt", 256'(dut.rd_cnt), 256'(m_rd));
        h_aw = slv_req.aw_valid && aw_ok && mst_resp.aw_ready;
        h_wl = slv_req.w_valid && w_ok && mst_resp.w_ready && slv_req.w.last;
        h_b  = mst_resp.b_valid && slv_req.b_ready;
        h_ar = slv_req.ar_valid && ar_ok && mst_resp.ar_ready;
        h_rl = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_mode = 0; m_wr = 0; m_wp = 0; m_rd = 0; m_err = 1'b0;
        end else begin
            case (m_mode)
                0: if (isolate) m_mode = 1;
                1: if (!isolate) m_mode = 0;
                   else if (m_wr == 0 && m_wp == 0 && m_rd == 0 && !h_b && !h_rl) m_mode = 2;
                default: if (!isolate) m_mode = 0;
            endcase
            if ((h_b && m_wr == 0) || (h_rl && m_rd == 0)) m_err = 1'b1;
            m_wr = m_wr + int'(h_aw) - ((h_b && m_wr > 0) ? 1 : 0);
            m_wp = m_wp + int'(h_aw) - int'(h_wl);
            m_rd = m_rd + int'(h_ar) - ((h_rl && m_rd > 0) ? 1 : 0);
        end
        #1;
    endtask

    task automatic step();
        eval_and_check();
        tick();
    endtask

    task automatic rand_inputs();
        ax_chan_t ax;
        rand_ax(ax);
        slv_req.aw       = ax;
        slv_req.aw_valid = 1'($urandom_range(0, 1));
        rand_ax(ax);
        slv_req.ar       = ax;
        slv_req.ar_valid = 1'($urandom_range(0, 1));
        slv_req.w.data   = $urandom;
        slv_req.w.strb   = strb_t'($urandom);
        slv_req.w.last   = ($urandom_range(0, 2) == 0);
        slv_req.w_valid  = 1'($urandom_range(0, 1));
        slv_req.b_ready  = ($urandom_range(0, 3) != 0);
        slv_req.r_ready  = ($urandom_range(0, 3) != 0);
        mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
        mst_resp.w_ready  = ($urandom_range(0, 3) != 0);
        mst_resp.ar_ready = ($urandom_range(0, 3) != 0);
        mst_resp.b.id     = id_t'($urandom);
        mst_resp.b.resp   = 2'($urandom);
        mst_resp.b_valid  = (m_wr > m_wp) && ($urandom_range(0, 1) == 1);
        mst_resp.r.id     = id_t'($urandom);
        mst_resp.r.data   = $urandom;
        mst_resp.r.resp   = 2'($urandom);
        mst_resp.r.last   = ($urandom_range(0, 1) == 1);
        mst_resp.r_valid  = (m_rd > 0) && ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        checks = 0; errors = 0;
        m_mode = 0; m_wr = 0; m_wp = 0; m_rd = 0; m_err = 1'b0;
        h_aw = 0; h_wl = 0; h_b = 0; h_ar = 0; h_rl = 0;
        idle();
        isolate = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: AW/AR open, W closed.
        slv_req.aw_valid = 1'b1; slv_req.w_valid = 1'b1; slv_req.ar_valid = 1'b1;
        eval_and_check();
        chk("rst_aw_open", 256'(mst_req.aw_valid), 256'(1));
        chk("rst_w_closed", 256'(slv_resp.w_ready), 256'(0));
        chk("rst_isolated", 256'(isolated), 256'(0));
        tick();
        idle();
        rst_n = 1'b1;
        step();

        // Basic write: id 3, 4 beats, W held until the cycle after AW.
        slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd3; slv_req.aw.len = 8'd3; slv_req.aw.addr = $urandom;
        slv_req.w_valid = 1'b1; slv_req.w.data = $urandom; slv_req.w.last = 1'b0;
        eval_and_check();
        chk("bw_w_held", 256'(mst_req.w_valid), 256'(0));
        chk("bw_aw_fwd", 256'(mst_req.aw_valid), 256'(1));
        tick();
        slv_req.aw_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            slv_req.w.data = $urandom;
            slv_req.w.last = (b == 3);
            eval_and_check();
            if (b == 0) chk("bw_w_first", 256'(mst_req.w_valid), 256'(1));
            tick();
        end
        slv_req.w_valid = 1'b0;
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd3;
        eval_and_check();
        chk("bw_b_fwd", 256'({slv_resp.b_valid, slv_resp.b.id}), 256'({1'b1, 4'd3}));
        tick();
        mst_resp.b_valid = 1'b0;
        eval_and_check();
        chk("bw_wr_zero", 256'(dut.wr_cnt), 256'(0));
        tick();

        // Read limit: third AR stalls until the cycle after the first last-R.
        idle();
        slv_req.ar_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slv_req.ar.id = id_t'(i);
            eval_and_check();
            if (i == 2) chk("rl_ar_stall", 256'(slv_resp.ar_ready), 256'(0));
            tick();
        end
        mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1; mst_resp.r.id = 4'd0;
        eval_and_check();
        chk("rl_still_closed", 256'(slv_resp.ar_ready), 256'(0));
        tick();
        mst_resp.r_valid = 1'b0;
        eval_and_check();
        chk("rl_reopen", 256'(slv_resp.ar_ready), 256'(1));
        tick();
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b1;
        repeat (2) step();

        // Drain: two writes and one half-finished read outstanding.
        idle();
        slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd1; slv_req.aw.len = 8'd1;
        step();
        slv_req.aw.id = 4'd2;
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd5; slv_req.ar.len = 8'd3;
        step();
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b0; mst_resp.r.id = 4'd5;
        repeat (2) step();
        mst_resp.r_valid = 1'b0;
        isolate = 1'b1;
        step();
        slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1;
        eval_and_check();
        chk("dr_aw_blocked", 256'(slv_resp.aw_ready), 256'(0));
        chk("dr_ar_blocked", 256'(mst_req.ar_valid), 256'(0));
        tick();
        slv_req.w_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            slv_req.w.last = (b % 2 == 1);
            step();
        end
        slv_req.w_valid = 1'b0;
        mst_resp.b_valid = 1'b1; mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b0;
        step();
        mst_resp.r.last = 1'b1;
        eval_and_check();
        chk("dr_not_yet", 256'(isolated), 256'(0));
        tick();
        mst_resp.b_valid = 1'b0; mst_resp.r_valid = 1'b0;
        n = 0;
        while (!isolated && n < 8) begin step(); n++; end
        chk("dr_isolated_reached", 256'(isolated), 256'(1));
        step();
        idle();
        isolate = 1'b0;
        step();
        chk("dr_released", 256'(isolated), 256'(0));

        // Abort: drain requested for three cycles with a write pending, then withdrawn.
        slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd7; slv_req.aw.len = 8'd0;
        step();
        slv_req.aw_valid = 1'b0;
        isolate = 1'b1;
        repeat (3) begin
            step();
            chk("ab_never_isolated", 256'(isolated), 256'(0));
        end
        isolate = 1'b0;
        step();
        slv_req.ar_valid = 1'b1; slv_req.ar.len = 8'd0;
        eval_and_check();
        chk("ab_ar_accept", 256'(slv_resp.ar_ready), 256'(1));
        tick();
        slv_req.ar_valid = 1'b0;
        slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
        step();
        slv_req.w_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        step();
        mst_resp.b_valid = 1'b0;
        mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
        step();
        idle();

        // Underflow: unsolicited B sets a sticky error, cleared only by reset.
        mst_resp.b_valid = 1'b1;
        step();
        mst_resp.b_valid = 1'b0;
        repeat (3) begin
            eval_and_check();
            chk("uf_sticky", 256'(cnt_err), 256'(1));
            chk("uf_cnt_zero", 256'(dut.wr_cnt), 256'(0));
            tick();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("uf_cleared", 256'(cnt_err), 256'(0));

        // Race: AW handshake in the same cycle isolate rises is counted and drained.
        slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd9; slv_req.aw.len = 8'd0;
        isolate = 1'b1;
        eval_and_check();
        chk("race_aw_taken", 256'(slv_resp.aw_ready), 256'(1));
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
        step();
        chk("race_counted", 256'(dut.wr_cnt), 256'(1));
        slv_req.w_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        step();
        mst_resp.b_valid = 1'b0;
        n = 0;
        while (!isolated && n < 8) begin step(); n++; end
        chk("race_isolated", 256'(isolated), 256'(1));
        isolate = 1'b0;
        step();

        // Randomized traffic with isolate toggling and one mid-run reset of both sides.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) isolate = ~isolate;
            rst_n = (i != 1500);
            rand_inputs();
            step();
        end
        rst_n = 1'b1;
        idle();
        isolate = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
